// File: rtl/phys_free_list_if.sv
// Dispatch / retire / flush bus of the physical-register free list.
// The slave modport is the free list; the master side is dispatch plus the ROB.
interface phys_free_list_if #(
    parameter int N_WAY  = 2,
    parameter int N_ROB  = 8,
    parameter int N_PRF  = 64,
    parameter int N_ARCH = 32
);
    localparam int TAG_BITS = $clog2(N_PRF);
    localparam int DEPTH    = N_PRF - N_ARCH;
    localparam int CNT_BITS = $clog2(DEPTH) + 1;
    localparam int AVL_BITS = $clog2(N_WAY) + 1;

    logic [N_WAY-1:0]               alloc_req;
    logic [N_WAY-1:0][TAG_BITS-1:0] alloc_tag;
    logic [N_WAY-1:0]               alloc_grant;
    logic [N_WAY-1:0]               retire_valid;
    logic [N_WAY-1:0][TAG_BITS-1:0] retire_told;
    logic                           branch_haz;
    logic [N_ROB-1:0][TAG_BITS-1:0] free_list_haz;
    logic [CNT_BITS-1:0]            free_count;
    logic [AVL_BITS-1:0]            avail_n;
    logic                           fl_error;

    modport master (
        output alloc_req, retire_valid, retire_told, branch_haz, free_list_haz,
        input  alloc_tag, alloc_grant, free_count, avail_n, fl_error
    );
    modport slave (
        input  alloc_req, retire_valid, retire_told, branch_haz, free_list_haz,
        output alloc_tag, alloc_grant, free_count, avail_n, fl_error
    );
endinterface

// File: rtl/phys_free_list.sv
// Circular free list of physical-register tags: N_WAY pops, N_WAY retire pushes and an
// N_ROB-wide flush push per cycle. Optional FREELIST_DUPCHECK_EN adds a duplicate-tag bitmap.
module phys_free_list_lane #(
    parameter int LANE     = 0,
    parameter int DEPTH    = 32,
    parameter int PTR_BITS = 5,
    parameter int CNT_BITS = 6
) (
    input  logic                req_run,
    input  logic                block,
    input  logic [PTR_BITS-1:0] head,
    input  logic [CNT_BITS-1:0] count,
    output logic [PTR_BITS-1:0] rd_idx,
    output logic                grant
);
    logic [PTR_BITS:0] sum;

    assign sum    = {1'b0, head} + (PTR_BITS+1)'(LANE);
    assign rd_idx = (sum >= (PTR_BITS+1)'(DEPTH)) ? PTR_BITS'(sum - (PTR_BITS+1)'(DEPTH))
                                                  : sum[PTR_BITS-1:0];
    assign grant  = req_run && !block && (count > CNT_BITS'(LANE));
endmodule

module phys_free_list #(
    parameter int N_WAY  = 2,
    parameter int N_ROB  = 8,
    parameter int N_PRF  = 64,
    parameter int N_ARCH = 32
) (
    input logic             clock,
    input logic             reset,
    phys_free_list_if.slave bus
);
    localparam int TAG_BITS = $clog2(N_PRF);
    localparam int DEPTH    = N_PRF - N_ARCH;
    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;
    localparam int AVL_BITS = $clog2(N_WAY) + 1;
    localparam int N_CAND   = N_WAY + N_ROB;

    logic [DEPTH-1:0][TAG_BITS-1:0]  mem;
    logic [PTR_BITS-1:0]             head, tail, head_next, tail_next;
    logic [CNT_BITS-1:0]             count, count_next, n_grant, n_push, space;
    logic                            fl_error_q, err_set;
    logic [N_WAY-1:0]                grant;
    logic [N_WAY-1:0][PTR_BITS-1:0]  rd_idx;
    logic [DEPTH-1:0]                wr_en;
    logic [DEPTH-1:0][TAG_BITS-1:0]  wr_tag;
    logic [N_CAND-1:0]               cand_vld;
    logic [N_CAND-1:0][TAG_BITS-1:0] cand_tag;
    logic [PTR_BITS:0]               head_sum;
`ifdef FREELIST_DUPCHECK_EN
    logic [N_PRF-1:0]                in_list, in_list_next, seen;
`endif

    // A lane is granted only if every lower lane also requests (contiguous run).
    genvar k;
    generate
        for (k = 0; k < N_WAY; k++) begin : g_lane
            phys_free_list_lane #(
                .LANE(k), .DEPTH(DEPTH), .PTR_BITS(PTR_BITS), .CNT_BITS(CNT_BITS)
            ) u_lane (
                .req_run (&bus.alloc_req[k:0]),
                .block   (bus.branch_haz | reset),
                .head    (head),
                .count   (count),
                .rd_idx  (rd_idx[k]),
                .grant   (grant[k])
            );
            assign bus.alloc_tag[k] = mem[rd_idx[k]];
        end
    endgenerate

    assign bus.alloc_grant = grant;
    assign bus.free_count  = count;
    assign bus.avail_n     = (count < CNT_BITS'(N_WAY)) ? AVL_BITS'(count) : AVL_BITS'(N_WAY);
    assign bus.fl_error    = fl_error_q;

    always_comb begin
        n_grant = '0;
        for (int i = 0; i < N_WAY; i++) n_grant = n_grant + CNT_BITS'(grant[i]);
        head_sum  = {1'b0, head} + n_grant;
        head_next = (head_sum >= (PTR_BITS+1)'(DEPTH)) ? PTR_BITS'(head_sum - (PTR_BITS+1)'(DEPTH))
                                                       : head_sum[PTR_BITS-1:0];
    end

    // Push candidates in priority order: retire lanes, then flush entries.
    always_comb begin
        for (int i = 0; i < N_WAY; i++) begin
            cand_tag[i] = bus.retire_told[i];
            cand_vld[i] = bus.retire_valid[i] && (bus.retire_told[i] != '0);
        end
        for (int j = 0; j < N_ROB; j++) begin
            cand_tag[N_WAY+j] = bus.free_list_haz[j];
            cand_vld[N_WAY+j] = bus.branch_haz && (bus.free_list_haz[j] != '0);
        end
    end

    // Space counts this cycle's pops; frees are never offered to allocation the same cycle.
    always_comb begin
        logic                keep;
        logic [PTR_BITS-1:0] wp;
        wr_en   = '0;
        wr_tag  = '0;
        n_push  = '0;
        err_set = 1'b0;
        keep    = 1'b0;
        wp      = tail;
        space   = CNT_BITS'(DEPTH) - count + n_grant;
`ifdef FREELIST_DUPCHECK_EN
        seen    = '0;
`endif
        for (int c = 0; c < N_CAND; c++) begin
            keep = cand_vld[c];
`ifdef FREELIST_DUPCHECK_EN
            if (keep && (in_list[cand_tag[c]] || seen[cand_tag[c]])) begin
                keep    = 1'b0;
                err_set = 1'b1;
            end
            if (keep) seen[cand_tag[c]] = 1'b1;
`endif
            if (keep && (n_push == space)) begin
                keep    = 1'b0;
                err_set = 1'b1;
            end
            if (keep) begin
                wr_en[wp]  = 1'b1;
                wr_tag[wp] = cand_tag[c];
                wp         = (wp == PTR_BITS'(DEPTH-1)) ? '0 : wp + 1'b1;
                n_push     = n_push + 1'b1;
            end
        end
        tail_next  = wp;
        count_next = count - n_grant + n_push;
    end

`ifdef FREELIST_DUPCHECK_EN
    always_comb begin
        in_list_next = in_list;
        for (int i = 0; i < N_WAY; i++)
            if (grant[i]) in_list_next[mem[rd_idx[i]]] = 1'b0;
        for (int d = 0; d < DEPTH; d++)
            if (wr_en[d]) in_list_next[wr_tag[d]] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) in_list <= {{DEPTH{1'b1}}, {N_ARCH{1'b0}}};
        else       in_list <= in_list_next;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= TAG_BITS'(N_ARCH + i);
            head       <= '0;
            tail       <= '0;
            count      <= CNT_BITS'(DEPTH);
            fl_error_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (wr_en[i]) mem[i] <= wr_tag[i];
            head       <= head_next;
            tail       <= tail_next;
            count      <= count_next;
            fl_error_q <= fl_error_q | err_set;
        end
    end
endmodule

// File: tb/tb_phys_free_list.sv
// Scoreboard bench for phys_free_list: a queue-based free-list model predicts each cycle,
// a monitor compares grants, offered tags, count, avail_n and fl_error.
module tb_phys_free_list;
    localparam int N_WAY = 2, N_ROB = 8, N_PRF = 64, N_ARCH = 32;
    localparam int TB = 6, DEPTH = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    phys_free_list_if #(.N_WAY(N_WAY), .N_ROB(N_ROB), .N_PRF(N_PRF), .N_ARCH(N_ARCH)) bus ();
    phys_free_list #(.N_WAY(N_WAY), .N_ROB(N_ROB), .N_PRF(N_PRF), .N_ARCH(N_ARCH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int grant;
        int tag0;
        int tag1;
        int cnt;
        int avail;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   fl_q[$];
    int   err_m;
    int   total = 0;
    int   bad   = 0;

    function automatic void chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

`ifdef FREELIST_DUPCHECK_EN
    function automatic bit in_q(input int q[$], input int v);
        foreach (q[i]) if (q[i] == v) return 1'b1;
        return 1'b0;
    endfunction
`endif

    // Reference: list of free tags in FIFO order; pops come off the front, pushes go on the back.
    task automatic model_step(input logic [1:0] req, input logic [1:0] rv, input int t0, input int t1,
                              input logic bh, input logic [N_ROB-1:0][TB-1:0] haz);
        exp_t e;
        int   run, ng;
        int   cand[$];
`ifdef FREELIST_DUPCHECK_EN
        int   pre[$];
        int   pushed[$];
        pre = fl_q;
`endif
        run = req[0] ? (req[1] ? 2 : 1) : 0;
        ng  = bh ? 0 : ((run < fl_q.size()) ? run : fl_q.size());
        e.grant = (1 << ng) - 1;
        e.tag0  = (fl_q.size() > 0) ? fl_q[0] : -1;
        e.tag1  = (fl_q.size() > 1) ? fl_q[1] : -1;
        e.cnt   = fl_q.size();
        e.avail = (fl_q.size() < 2) ? fl_q.size() : 2;
        e.err   = err_m;
        exp_q.push_back(e);

        repeat (ng) void'(fl_q.pop_front());
        if (rv[0] && t0 != 0) cand.push_back(t0);
        if (rv[1] && t1 != 0) cand.push_back(t1);
        if (bh) for (int j = 0; j < N_ROB; j++) if (haz[j] != 0) cand.push_back(int'(haz[j]));
        foreach (cand[c]) begin
`ifdef FREELIST_DUPCHECK_EN
            if (in_q(pre, cand[c]) || in_q(pushed, cand[c])) begin
                err_m = 1;
                continue;
            end
            pushed.push_back(cand[c]);
`endif
            if (fl_q.size() >= DEPTH) begin
                err_m = 1;
                continue;
            end
            fl_q.push_back(cand[c]);
        end
    endtask

    task automatic cyc(input logic [1:0] req, input logic [1:0] rv, input int t0, input int t1,
                       input logic bh, input logic [N_ROB-1:0][TB-1:0] haz);
        @(posedge clock);
        #2;
        bus.alloc_req      = req;
        bus.retire_valid   = rv;
        bus.retire_told[0] = TB'(t0);
        bus.retire_told[1] = TB'(t1);
        bus.branch_haz     = bh;
        bus.free_list_haz  = haz;
        model_step(req, rv, t0, t1, bh, haz);
    endtask

    task automatic idle_inputs();
        bus.alloc_req     = '0;
        bus.retire_valid  = '0;
        bus.retire_told   = '0;
        bus.branch_haz    = 1'b0;
        bus.free_list_haz = '0;
    endtask

    // Reset with arbitrary traffic applied; the DUT must ignore it.
    task automatic do_reset(input logic [1:0] req, input logic [1:0] rv);
        @(posedge clock);
        #2;
        reset              = 1'b1;
        bus.alloc_req      = req;
        bus.retire_valid   = rv;
        bus.retire_told[0] = TB'(11);
        bus.retire_told[1] = TB'(12);
        bus.branch_haz     = 1'b0;
        bus.free_list_haz  = '0;
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        idle_inputs();
        fl_q.delete();
        for (int i = 0; i < DEPTH; i++) fl_q.push_back(N_ARCH + i);
        err_m = 0;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #4;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("alloc_grant", int'(bus.alloc_grant), e.grant);
                if (e.tag0 >= 0) chk("alloc_tag0", int'(bus.alloc_tag[0]), e.tag0);
                if (e.tag1 >= 0) chk("alloc_tag1", int'(bus.alloc_tag[1]), e.tag1);
                chk("free_count", int'(bus.free_count), e.cnt);
                chk("avail_n", int'(bus.avail_n), e.avail);
                chk("fl_error", int'(bus.fl_error), e.err);
            end
        end
    end

    initial begin
        logic [N_ROB-1:0][TB-1:0] z, haz;
        logic [1:0]               req, rv;
        z = '0;
        idle_inputs();
        do_reset(2'b00, 2'b00);

        // first allocation, then drain to empty
        cyc(2'b11, 2'b00, 0, 0, 1'b0, z);
        cyc(2'b00, 2'b00, 0, 0, 1'b0, z);
        repeat (15) cyc(2'b11, 2'b00, 0, 0, 1'b0, z);
        cyc(2'b11, 2'b00, 0, 0, 1'b0, z);
        cyc(2'b00, 2'b01, 5, 0, 1'b0, z);
        // count=1: pop one, push two
        cyc(2'b11, 2'b11, 6, 7, 1'b0, z);
        cyc(2'b00, 2'b00, 0, 0, 1'b0, z);

        // flush with simultaneous retire and blocked allocation
        haz = '0;
        haz[0] = TB'(43);
        haz[1] = TB'(42);
        haz[3] = TB'(41);
        haz[4] = TB'(40);
        cyc(2'b11, 2'b01, 9, 0, 1'b1, haz);
        repeat (4) cyc(2'b11, 2'b00, 0, 0, 1'b0, z);
        cyc(2'b00, 2'b00, 0, 0, 1'b0, z);

        // steady-state wrap: one pop and one fresh push per cycle at full
        do_reset(2'b00, 2'b00);
        for (int i = 0; i < 40; i++) cyc(2'b01, 2'b01, (i < 31) ? i + 1 : i + 1, 0, 1'b0, z);
        cyc(2'b00, 2'b00, 0, 0, 1'b0, z);

        // overflow at full
        do_reset(2'b00, 2'b00);
        cyc(2'b00, 2'b01, 50, 0, 1'b0, z);
        cyc(2'b00, 2'b00, 0, 0, 1'b0, z);
        cyc(2'b11, 2'b00, 0, 0, 1'b0, z);

        // reset in the middle of traffic
        do_reset(2'b11, 2'b11);
        cyc(2'b00, 2'b00, 0, 0, 1'b0, z);

        // random traffic, alternating fill-biased and drain-biased phases
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset(2'b01, 2'b10);
            req = 2'($urandom_range(0, 3));
            if ((n % 80) < 40) rv = 2'($urandom_range(0, 3));
            else               rv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            haz = '0;
            for (int j = 0; j < N_ROB; j++)
                if ($urandom_range(0, 1) == 1) haz[j] = TB'($urandom_range(1, 63));
            cyc(req, rv, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                ($urandom_range(0, 9) == 0), haz);
        end
        cyc(2'b00, 2'b00, 0, 0, 1'b0, z);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clock);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: left %0d expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
